psram_line_fetcher: RTL and testbench
=====================================

# psram_line_fetcher

Scanline prefetcher between the `psram` controller and the video colour output. It streams one 320-pixel source row per two display lines from PSRAM into a two-bank line buffer, reading during the preceding display line. It then plays the row back, doubled horizontally and vertically, as 12-bit colour in step with the VGA timing counters. All logic runs in the `clk_100mhz` domain, with a one-cycle pixel strobe derived from the pixel-clock divider.

## Interface
Parameters:
- `LINE_WORDS`, 320: source pixels per row; one 16-bit PSRAM word per pixel, bits [11:0] used.
- `SRC_ROWS`, 240: source rows per frame.

Ports:
- `clk_i` in 1: 100 MHz clock.
- `rstn_i` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_enable` in 1: permits new fetches to start.
- `i_base_addr` in 24: byte address of source row 0, column 0.
- `i_pix_en` in 1: one-cycle strobe, once per pixel.
- `i_h_count` in 10: horizontal counter. Visible range is 0..639.
- `i_v_count` in 9: vertical counter. Visible range is 0..479.
- `i_de` in 1: display enable.
- `o_psram_stb` out 1: request strobe to the `psram` controller.
- `o_psram_we` out 1: write enable. Constant 0.
- `o_psram_addr` out 24: request byte address.
- `o_psram_din` out 16: write data. Constant 0.
- `i_psram_busy` in 1: controller busy.
- `i_psram_done` in 1: one-cycle pulse; read data is valid on `i_psram_dout`.
- `i_psram_dout` in 16: read data.
- `o_color` out 12: pixel colour, {R,G,B}.
- `o_busy` out 1: a fetch is in progress.
- `o_underrun` out 1: sticky error flag.
- `i_clr_underrun` in 1: clears `o_underrun`.

## Operation
Reset values:
- All outputs are 0.
- The FSM is in IDLE.
- The column counter is 0.

Row-to-bank mapping:
- Source row r is stored in bank r[0].
- Display line v reads source row v>>1 from bank (v>>1)[0], column `i_h_count`>>1.

Fetch triggers (`trig`):
- A trigger fires on a cycle with `i_pix_en`=1, `i_h_count`=639, `i_v_count`<480 and `i_enable`=1, provided one of these holds:
  - v is even and v≠478: target row is (v>>1)+1.
  - v = 479: target row is 0.

Fetch FSM:
- IDLE: on `trig`, latch the target row and set the column to 0, then go to ISSUE.
- ISSUE: when `i_psram_busy`=0, assert `o_psram_stb` for exactly one cycle with the request address, then go to WAIT.
  - Request address = `i_base_addr` + ((row·LINE_WORDS + col)<<1), truncated modulo 2^24.
- WAIT: on `i_psram_done`, write `i_psram_dout`[11:0] to bank row[0] at index col.
  - If col = LINE_WORDS−1, go to IDLE.
  - Otherwise increment col and go to ISSUE.
- `o_busy` = (state ≠ IDLE).

Underrun:
- A trigger arriving while the FSM is not in IDLE sets `o_underrun` and restarts the fetch with the new row and col=0.
- If the restart happens in WAIT, the outstanding `i_psram_done` is consumed without writing the buffer.
- After a restart, the FSM never issues a strobe while `i_psram_busy`=1.
- If `trig` and `i_clr_underrun` occur in the same cycle, the set wins.

Enable:
- `i_enable`=0 blocks new triggers only. A fetch already in flight completes.

Playback:
- On every `i_pix_en`, the buffer read address is presented.
- `o_color` updates exactly one `clk_i` cycle later:
  - buffer data if `i_de` was 1 at the strobe;
  - 12'h000 if `i_de` was 0.
- `o_color` holds its value between updates.

Buffer access:
- A same-cycle read and write to the same bank and index returns the old data. Under normal timing this cannot happen, because fetch and playback always use opposite banks.

Reset mid-fetch:
- The FSM returns to IDLE immediately and `o_psram_stb` drops.
- Buffer contents are undefined until the next complete fetch.

## Timing
- Request latency: `o_psram_stb` asserts 1 cycle after `trig` if `i_psram_busy`=0. Between words, the strobe follows `i_psram_done` by 1 cycle, plus any busy stall.
- Bandwidth budget: 320 reads must finish within one line (800 px × 4 clk = 3200 cycles), so there are at most 10 cycles per read. Exceeding this produces an underrun at the next trigger.
- Colour latency: 1 clk after `i_pix_en`, well inside the 4-clk pixel period.
- Vertical blank: the row-0 fetch runs after line 479 and must finish before line 0. The whole blanking interval is available.

## Structure
- Package `ogege_pkg` holds:
  - constants `H_ACTIVE`=640, `V_ACTIVE`=480, `COLOR_W`=12, `PSRAM_AW`=24, `PSRAM_DW`=16;
  - the enum `fetch_state_t` {IDLE, ISSUE, WAIT}.
- Sub-module `line_ram`: two banks of LINE_WORDS×12, with one write port and one registered read port. Bank select is the MSB of the address.

## Test plan
- **Reset:** hold `rstn_i`=0 mid-fetch → all outputs 0, state IDLE, next strobe only after a new `trig`.
- **Single fetch:** base 0x000100, trigger at v=0 end → row 1; first address is 0x000380 (0x100+320·2); 320 strobes; last address 0x0005FE; `o_busy` falls after the 320th done.
- **Playback:** preload row 5 with col n = n; v=10, h=7 → `o_color`=3 one clk after the strobe; v=11 gives identical output.
- **Frame wrap:** end of v=479 → row 0 is fetched into bank 0, starting at address = base; no trigger fires at v=478.
- **Underrun:** controller done latency is 20 cycles → `o_underrun`=1 at the next trigger, the fetch restarts at col 0, and the stale done is not written; `i_clr_underrun` then clears the flag.
- **Blanking/busy:** `i_de`=0 → `o_color`=0; `i_psram_busy` held high for 50 cycles → no strobe until it drops.

Source files
------------

// File: rtl/ogege_pkg.sv
// Shared constants, fetch FSM state type and PSRAM address helper for the
// video line prefetch path.
package ogege_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COLOR_W  = 12;
  localparam int unsigned PSRAM_AW = 24;
  localparam int unsigned PSRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } fetch_state_t;

  // Byte address of one 16-bit pixel word; wraps modulo the PSRAM address space.
  function automatic logic [PSRAM_AW-1:0] word_byte_addr(
    input logic [PSRAM_AW-1:0] base,
    input int unsigned         row,
    input int unsigned         col,
    input int unsigned         words
  );
    int unsigned off;
    off = (row * words + col) << 1;
    return base + off[PSRAM_AW-1:0];
  endfunction

endpackage

// File: rtl/psram_line_fetcher_line_ram.sv
// Two-bank scanline buffer: one write port, one registered read port.
// Address MSB selects the bank; a same-cycle read/write returns the old data.
module line_ram #(
  parameter int unsigned LINE_WORDS = 320,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned IW         = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              we_i,
  input  logic [IW:0]       waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IW:0]       raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2][LINE_WORDS];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wbank, rbank;
  logic [IW-1:0]     widx, ridx;

  assign wbank   = waddr_i[IW];
  assign widx    = waddr_i[IW-1:0];
  assign rbank   = raddr_i[IW];
  assign ridx    = raddr_i[IW-1:0];
  assign rdata_o = rdata_q;

  // Write port: ignore indices past the end of the row.
  always_ff @(posedge clk_i) begin
    if (we_i && (32'(widx) < LINE_WORDS)) begin
      mem[wbank][widx] <= wdata_i;
    end
  end

  // Read data is held between read requests.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = (32'(ridx) < LINE_WORDS) ? mem[rbank][ridx] : '0;
    end
  end

  // Registered read output.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/psram_line_fetcher.sv
// Scanline prefetcher: fetches one source row per two display lines from
// PSRAM into a two-bank line buffer and plays it back pixel/line doubled.
module psram_line_fetcher
  import ogege_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 320,
  parameter int unsigned SRC_ROWS   = 240
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                i_enable,
  input  logic [PSRAM_AW-1:0] i_base_addr,
  input  logic                i_pix_en,
  input  logic [9:0]          i_h_count,
  input  logic [8:0]          i_v_count,
  input  logic                i_de,
  output logic                o_psram_stb,
  output logic                o_psram_we,
  output logic [PSRAM_AW-1:0] o_psram_addr,
  output logic [PSRAM_DW-1:0] o_psram_din,
  input  logic                i_psram_busy,
  input  logic                i_psram_done,
  input  logic [PSRAM_DW-1:0] i_psram_dout,
  output logic [COLOR_W-1:0]  o_color,
  output logic                o_busy,
  output logic                o_underrun,
  input  logic                i_clr_underrun
);

  localparam int unsigned IW = $clog2(LINE_WORDS);
  localparam int unsigned RW = $clog2(SRC_ROWS);

  fetch_state_t        state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [IW-1:0]       col_q, col_d;
  logic [PSRAM_AW-1:0] addr_q, addr_d;
  logic                drop_q, drop_d;
  logic                underrun_q, underrun_d;
  logic                de_q, de_d;

  logic                trig, v_last, v_trig_line, stb, ram_we;
  logic [RW-1:0]       trig_row;
  logic [COLOR_W-1:0]  ram_rdata;
  logic                unused_dout;

  assign unused_dout = ^i_psram_dout[PSRAM_DW-1:COLOR_W];

  // Fetch trigger at the end of each visible line that precedes a new source row.
  always_comb begin
    v_last      = (i_v_count == 9'(V_ACTIVE - 1));
    v_trig_line = (~i_v_count[0] && (i_v_count != 9'(V_ACTIVE - 2))) || v_last;
    trig        = i_pix_en && i_enable && (i_h_count == 10'(H_ACTIVE - 1)) &&
                  (i_v_count < 9'(V_ACTIVE)) && v_trig_line;
    trig_row    = v_last ? '0 : RW'(i_v_count >> 1) + RW'(1);
  end

  // A strobe is held back while a discarded response is still owed.
  assign stb = (state_q == ISSUE) && !i_psram_busy && !drop_q;

  // Fetch FSM next state; a retrigger while busy overrides the normal step.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    underrun_d = underrun_q;
    ram_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = ISSUE;
          row_d   = trig_row;
          col_d   = '0;
        end
      end
      ISSUE: begin
        if (drop_q && i_psram_done) begin
          drop_d = 1'b0;
        end
        if (stb) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_psram_done) begin
          ram_we = 1'b1;
          if (32'(col_q) == LINE_WORDS - 1) begin
            state_d = IDLE;
          end else begin
            col_d   = col_q + IW'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_clr_underrun) begin
      underrun_d = 1'b0;
    end

    // Restart: any request still in flight after this cycle (including one
    // strobed this very cycle) must have its response swallowed.
    if (trig && (state_q != IDLE)) begin
      underrun_d = 1'b1;
      state_d    = ISSUE;
      row_d      = trig_row;
      col_d      = '0;
      ram_we     = 1'b0;
      drop_d     = ((state_q == WAIT) || stb || drop_q) && !i_psram_done;
    end

    if (state_d == ISSUE) begin
      addr_d = word_byte_addr(i_base_addr, 32'(row_d), 32'(col_d), LINE_WORDS);
    end
  end

  // Fetch FSM registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      drop_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      underrun_q <= underrun_d;
    end
  end

  // Capture display enable alongside each buffer read.
  always_comb begin
    de_d = de_q;
    if (i_pix_en) begin
      de_d = i_de;
    end
  end

  // Playback blanking flag register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      de_q <= 1'b0;
    end else begin
      de_q <= de_d;
    end
  end

  line_ram #(
    .LINE_WORDS(LINE_WORDS),
    .DATA_W    (COLOR_W)
  ) u_line_ram (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .we_i   (ram_we),
    .waddr_i({row_q[0], col_q}),
    .wdata_i(i_psram_dout[COLOR_W-1:0]),
    .re_i   (i_pix_en),
    .raddr_i({i_v_count[1], IW'(i_h_count >> 1)}),
    .rdata_o(ram_rdata)
  );

  assign o_psram_stb  = stb;
  assign o_psram_we   = 1'b0;
  assign o_psram_addr = addr_q;
  assign o_psram_din  = '0;
  assign o_busy       = (state_q != IDLE);
  assign o_underrun   = underrun_q;
  assign o_color      = de_q ? ram_rdata : '0;

endmodule

// File: tb/tb_psram_line_fetcher.sv
// Self-checking bench for psram_line_fetcher with a behavioural PSRAM and
// a row/bank-level model of the line buffer.
module tb_psram_line_fetcher;

  localparam int LW = 320;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rstn_i, i_enable, i_pix_en, i_de, i_clr_underrun;
  logic [23:0] i_base_addr;
  logic [9:0]  i_h_count;
  logic [8:0]  i_v_count;
  logic        o_psram_stb, o_psram_we, i_psram_busy, i_psram_done;
  logic [23:0] o_psram_addr;
  logic [15:0] o_psram_din, i_psram_dout;
  logic [11:0] o_color;
  logic        o_busy, o_underrun;

  logic        busy_force, busy_m;
  int          checks = 0, failures = 0;
  int          lat = 1, cnt = 0, busy_viol = 0, data_mode = 0;
  logic [23:0] mode_base = '0, pend = '0;
  logic [23:0] stb_log[$];
  logic [11:0] exp_buf[2][LW];

  assign i_psram_busy = busy_m | busy_force;

  psram_line_fetcher #(.LINE_WORDS(320), .SRC_ROWS(240)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .i_enable(i_enable), .i_base_addr(i_base_addr),
    .i_pix_en(i_pix_en), .i_h_count(i_h_count), .i_v_count(i_v_count), .i_de(i_de),
    .o_psram_stb(o_psram_stb), .o_psram_we(o_psram_we), .o_psram_addr(o_psram_addr),
    .o_psram_din(o_psram_din), .i_psram_busy(i_psram_busy), .i_psram_done(i_psram_done),
    .i_psram_dout(i_psram_dout), .o_color(o_color), .o_busy(o_busy),
    .o_underrun(o_underrun), .i_clr_underrun(i_clr_underrun)
  );

  // PSRAM content: address hash, or the column index relative to mode_base.
  function automatic logic [15:0] mem_word(input logic [23:0] a);
    logic [31:0] x;
    logic [23:0] d;
    if (data_mode == 1) begin
      d = a - mode_base;
      return 16'((32'(d) >> 1) % LW);
    end
    x = {8'h0, a} * 32'h9E3779B1;
    return x[31:16] ^ {4'h0, a[11:0]};
  endfunction

  function automatic logic [23:0] exp_addr(input logic [23:0] b, input int r, input int c);
    int unsigned off;
    off = (r * LW + c) * 2;
    return b + off[23:0];
  endfunction

  // Behavioural PSRAM: busy from strobe until the done pulse, lat cycles later.
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_m <= 1'b0; cnt <= 0; i_psram_done <= 1'b0; i_psram_dout <= '0;
    end else begin
      i_psram_done <= 1'b0;
      if (o_psram_stb) begin
        if (i_psram_busy) busy_viol <= busy_viol + 1;
        stb_log.push_back(o_psram_addr);
        pend <= o_psram_addr; cnt <= lat; busy_m <= 1'b1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          i_psram_done <= 1'b1; i_psram_dout <= mem_word(pend); busy_m <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_trig(input int v, input logic en);
    i_v_count = 9'(v); i_h_count = 10'd639; i_pix_en = 1'b1; i_enable = en;
    tick();
    i_pix_en = 1'b0; i_enable = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!o_busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  function automatic int row_of(input int v);
    return (v == 479) ? 0 : v / 2 + 1;
  endfunction

  task automatic fill_model(input logic [23:0] b, input int r);
    logic [15:0] w;
    for (int c = 0; c < LW; c++) begin
      w = mem_word(exp_addr(b, r, c));
      exp_buf[r % 2][c] = w[11:0];
    end
  endtask

  task automatic count_bad(input logic [23:0] b, input int r, output int n_bad);
    n_bad = 0;
    for (int i = 0; i < stb_log.size(); i++)
      if (stb_log[i] !== exp_addr(b, r, i)) n_bad++;
  endtask

  task automatic fetch_row(input int v, input logic [23:0] b, output bit ok,
                           output int n_stb, output int n_bad);
    stb_log.delete();
    i_base_addr = b;
    do_trig(v, 1'b1);
    wait_idle(8000, ok);
    n_stb = stb_log.size();
    count_bad(b, row_of(v), n_bad);
    if (ok) fill_model(b, row_of(v));
  endtask

  task automatic play(input int v, input int h, input logic de, output logic [11:0] got);
    i_v_count = 9'(v); i_h_count = 10'(h); i_de = de; i_pix_en = 1'b1;
    tick();
    i_pix_en = 1'b0;
    got = o_color;
  endtask

  task automatic test_reset();
    bit ok;
    rstn_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({o_psram_stb, o_psram_we, o_psram_addr, o_psram_din, o_color, o_busy, o_underrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got stb=%b we=%b addr=%h din=%h color=%h busy=%b und=%b exp all 0",
               o_psram_stb, o_psram_we, o_psram_addr, o_psram_din, o_color, o_busy, o_underrun);
    end
    rstn_i = 1'b1; tick();
    lat = 3; i_base_addr = 24'h123456;
    do_trig(0, 1'b1);
    repeat (20) tick();
    checks++;
    if (o_busy !== 1'b1) begin failures++; $display("FAIL reset_prefetch_busy got=%b exp=1", o_busy); end
    rstn_i = 1'b0; #1;
    checks++;
    if ({o_busy, o_psram_stb, o_psram_addr} !== '0) begin
      failures++; $display("FAIL reset_midfetch got busy=%b stb=%b addr=%h exp 0", o_busy, o_psram_stb, o_psram_addr);
    end
    tick(); tick(); rstn_i = 1'b1; tick();
    stb_log.delete();
    repeat (60) tick();
    checks++;
    if (stb_log.size() != 0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL reset_no_restart got strobes=%0d busy=%b exp 0 0", stb_log.size(), o_busy);
    end
    i_base_addr = 24'h000200;
    do_trig(2, 1'b1);
    checks++;
    if (o_psram_stb !== 1'b1) begin failures++; $display("FAIL reset_new_trig got stb=%b exp=1", o_psram_stb); end
    wait_idle(8000, ok);
  endtask

  task automatic test_single_fetch();
    bit ok; int n_bad, vl, h; logic [11:0] got, exp;
    lat = 1; data_mode = 0;
    stb_log.delete();
    i_base_addr = 24'h000100;
    do_trig(0, 1'b1);
    checks++;
    if (o_psram_stb !== 1'b1 || o_psram_addr !== 24'h000380) begin
      failures++; $display("FAIL single_first_req got stb=%b addr=%h exp 1 000380", o_psram_stb, o_psram_addr);
    end
    wait_idle(8000, ok);
    checks++;
    if (!ok || stb_log.size() != LW) begin
      failures++; $display("FAIL single_count got done=%0d strobes=%0d exp 1 320", ok, stb_log.size());
    end
    checks++;
    if (stb_log.size() < LW || stb_log[LW-1] !== 24'h0005FE) begin
      failures++; $display("FAIL single_last_addr got=%h exp=0005fe", (stb_log.size() >= LW) ? stb_log[LW-1] : 24'h0);
    end
    count_bad(24'h000100, 1, n_bad);
    checks++;
    if (n_bad != 0) begin failures++; $display("FAIL single_addr_seq got bad=%0d exp 0", n_bad); end
    fill_model(24'h000100, 1);
    for (int k = 0; k < 6; k++) begin
      vl = 2 + int'($urandom_range(0, 1)); h = int'($urandom_range(0, 639));
      play(vl, h, 1'b1, got);
      exp = exp_buf[1][h / 2];
      checks++;
      if (got !== exp) begin failures++; $display("FAIL single_play v=%0d h=%0d got=%h exp=%h", vl, h, got, exp); end
    end
  endtask

  task automatic test_playback();
    bit ok; int n_stb, n_bad, h, vl; logic [11:0] got;
    data_mode = 1; mode_base = 24'h000100; lat = 2;
    fetch_row(8, 24'h000100, ok, n_stb, n_bad);
    checks++;
    if (!ok || n_stb != LW || n_bad != 0) begin
      failures++; $display("FAIL play_fetch got done=%0d strobes=%0d bad=%0d exp 1 320 0", ok, n_stb, n_bad);
    end
    play(10, 7, 1'b1, got);
    checks++;
    if (got !== 12'd3) begin failures++; $display("FAIL play_v10_h7 got=%h exp=003", got); end
    play(11, 7, 1'b1, got);
    checks++;
    if (got !== 12'd3) begin failures++; $display("FAIL play_v11_h7 got=%h exp=003", got); end
    repeat (3) tick();
    checks++;
    if (o_color !== 12'd3) begin failures++; $display("FAIL play_hold got=%h exp=003", o_color); end
    for (int k = 0; k < 6; k++) begin
      vl = 10 + int'($urandom_range(0, 1)); h = int'($urandom_range(0, 639));
      play(vl, h, 1'b1, got);
      checks++;
      if (got !== 12'(h / 2)) begin failures++; $display("FAIL play_col v=%0d h=%0d got=%h exp=%h", vl, h, got, 12'(h / 2)); end
    end
    data_mode = 0;
  endtask

  task automatic test_frame_wrap();
    bit ok; int n_stb, n_bad, h; logic [11:0] got, exp;
    lat = 1; stb_log.delete();
    i_base_addr = 24'hFFFF00;
    do_trig(478, 1'b1);
    do_trig(5, 1'b1);
    repeat (10) tick();
    checks++;
    if (o_busy !== 1'b0 || stb_log.size() != 0) begin
      failures++; $display("FAIL wrap_no_trig_478 got busy=%b strobes=%0d exp 0 0", o_busy, stb_log.size());
    end
    fetch_row(479, 24'hFFFF00, ok, n_stb, n_bad);
    checks++;
    if (!ok || n_stb != LW || n_bad != 0) begin
      failures++; $display("FAIL wrap_fetch got done=%0d strobes=%0d bad=%0d exp 1 320 0", ok, n_stb, n_bad);
    end
    checks++;
    if (n_stb == 0 || stb_log[0] !== 24'hFFFF00) begin
      failures++; $display("FAIL wrap_first_addr got=%h exp=ffff00", (n_stb > 0) ? stb_log[0] : 24'h0);
    end
    for (int k = 0; k < 4; k++) begin
      h = (k == 0) ? 639 : int'($urandom_range(0, 639));
      play(k % 2, h, 1'b1, got);
      exp = exp_buf[0][h / 2];
      checks++;
      if (got !== exp) begin failures++; $display("FAIL wrap_play h=%0d got=%h exp=%h", h, got, exp); end
    end
  endtask

  task automatic test_underrun();
    bit ok; int n_bad, guard; logic [23:0] b;
    b = 24'h040000 + 24'($urandom_range(0, 4095));
    lat = 20; stb_log.delete(); i_base_addr = b;
    do_trig(0, 1'b1);
    guard = 0;
    while (stb_log.size() < 3 && guard < 500) begin tick(); guard++; end
    repeat (3) tick();
    checks++;
    if (o_underrun !== 1'b0 || stb_log.size() < 3) begin
      failures++; $display("FAIL underrun_pre got und=%b strobes=%0d exp 0 >=3", o_underrun, stb_log.size());
    end
    lat = 1;
    do_trig(2, 1'b1);
    stb_log.delete();
    checks++;
    if (o_underrun !== 1'b1 || o_busy !== 1'b1) begin
      failures++; $display("FAIL underrun_set got und=%b busy=%b exp 1 1", o_underrun, o_busy);
    end
    wait_idle(8000, ok);
    count_bad(b, 2, n_bad);
    checks++;
    if (!ok || stb_log.size() != LW || n_bad != 0) begin
      failures++; $display("FAIL underrun_restart got done=%0d strobes=%0d bad=%0d exp 1 320 0", ok, stb_log.size(), n_bad);
    end
    if (ok) fill_model(b, 2);
    i_clr_underrun = 1'b1; tick(); i_clr_underrun = 1'b0;
    checks++;
    if (o_underrun !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%b exp=0", o_underrun); end
    do_trig(6, 1'b1);
    repeat (5) tick();
    i_v_count = 9'd10; i_h_count = 10'd639; i_pix_en = 1'b1; i_enable = 1'b1; i_clr_underrun = 1'b1;
    tick();
    i_pix_en = 1'b0; i_enable = 1'b0; i_clr_underrun = 1'b0;
    stb_log.delete();
    checks++;
    if (o_underrun !== 1'b1) begin failures++; $display("FAIL underrun_set_wins got=%b exp=1", o_underrun); end
    wait_idle(8000, ok);
    count_bad(b, 6, n_bad);
    checks++;
    if (!ok || stb_log.size() != LW || n_bad != 0) begin
      failures++; $display("FAIL underrun_restart2 got done=%0d strobes=%0d bad=%0d exp 1 320 0", ok, stb_log.size(), n_bad);
    end
    if (ok) fill_model(b, 6);
    i_clr_underrun = 1'b1; tick(); i_clr_underrun = 1'b0;
  endtask

  task automatic test_blank_busy();
    bit ok; int h, seen; logic [11:0] got;
    h = int'($urandom_range(0, 639));
    play(12, h, 1'b1, got);
    play(12, h, 1'b0, got);
    checks++;
    if (got !== 12'h000) begin failures++; $display("FAIL blank_color got=%h exp=000", got); end
    busy_force = 1'b1; stb_log.delete(); i_base_addr = 24'h001000;
    do_trig(0, 1'b1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_psram_stb === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || stb_log.size() != 0 || o_busy !== 1'b1) begin
      failures++; $display("FAIL busy_hold got stb_seen=%0d strobes=%0d busy=%b exp 0 0 1", seen, stb_log.size(), o_busy);
    end
    busy_force = 1'b0; #1;
    checks++;
    if (o_psram_stb !== 1'b1 || o_psram_addr !== 24'h001280) begin
      failures++; $display("FAIL busy_release got stb=%b addr=%h exp 1 001280", o_psram_stb, o_psram_addr);
    end
    wait_idle(8000, ok);
    if (ok) fill_model(24'h001000, 1);
  endtask

  task automatic test_enable();
    bit ok;
    stb_log.delete();
    do_trig(0, 1'b0);
    repeat (10) tick();
    checks++;
    if (o_busy !== 1'b0 || stb_log.size() != 0) begin
      failures++; $display("FAIL enable_block got busy=%b strobes=%0d exp 0 0", o_busy, stb_log.size());
    end
    i_base_addr = 24'h002000; lat = 3;
    do_trig(0, 1'b1);
    i_enable = 1'b0;
    wait_idle(8000, ok);
    checks++;
    if (!ok || stb_log.size() != LW) begin
      failures++; $display("FAIL enable_inflight got done=%0d strobes=%0d exp 1 320", ok, stb_log.size());
    end
    if (ok) fill_model(24'h002000, 1);
  endtask

  task automatic test_back_to_back();
    bit ok; int n_stb, n_bad, v, r, vl, h; logic de; logic [23:0] b; logic [11:0] got, exp;
    for (int it = 0; it < 6; it++) begin
      v = ($urandom_range(0, 4) == 0) ? 479 : 2 * int'($urandom_range(0, 238));
      b = 24'($urandom);
      lat = int'($urandom_range(1, 4));
      fetch_row(v, b, ok, n_stb, n_bad);
      checks++;
      if (!ok || n_stb != LW || n_bad != 0) begin
        failures++; $display("FAIL b2b_fetch v=%0d got done=%0d strobes=%0d bad=%0d exp 1 320 0", v, ok, n_stb, n_bad);
      end
      r = row_of(v);
      for (int k = 0; k < 4; k++) begin
        vl = 2 * r + int'($urandom_range(0, 1)); h = int'($urandom_range(0, 639));
        de = 1'($urandom_range(0, 3) != 0);
        play(vl, h, de, got);
        exp = de ? exp_buf[r % 2][h / 2] : 12'h000;
        checks++;
        if (got !== exp) begin failures++; $display("FAIL b2b_play v=%0d h=%0d de=%b got=%h exp=%h", vl, h, de, got, exp); end
      end
    end
  endtask

  initial begin
    rstn_i = 1'b0; i_enable = 1'b0; i_pix_en = 1'b0; i_de = 1'b0; i_clr_underrun = 1'b0;
    i_base_addr = '0; i_h_count = '0; i_v_count = '0; busy_force = 1'b0;
    test_reset();
    test_single_fetch();
    test_playback();
    test_frame_wrap();
    test_underrun();
    test_blank_busy();
    test_enable();
    test_back_to_back();
    checks++;
    if (busy_viol != 0) begin failures++; $display("FAIL strobe_while_busy got=%0d exp=0", busy_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
